// File: rtl/sram_23lc1024_responder_if.sv
// SPI pin bundle for the 23LC1024 responder: the initiator drives CSn/SCK/SI/HOLDn
// and the responder drives SO.
interface sram_23lc1024_responder_if;
   logic CSn;
   logic SCK;
   logic SI;
   logic HOLDn;
   logic SO;

   modport master (output CSn, output SCK, output SI, output HOLDn, input SO);
   modport slave  (input CSn, input SCK, input SI, input HOLDn, output SO);
endinterface

// File: rtl/sram_23lc1024_responder.sv
// Device-side emulation of a 23LC1024 serial SRAM (SPI mode 0) backed by a byte array.
// Define SRAM_RSP_MODE_REG_EN to add the mode register (WRMR/RDMR, byte/page/sequential).
module sram_23lc1024_responder #(
   parameter int ADDR_BITS = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   sram_23lc1024_responder_if.slave spi,
   output logic                     selected,
   output logic                     wr_strobe,
   output logic [ADDR_BITS-1:0]     wr_addr,
   output logic [7:0]               wr_data,
   output logic                     cmd_err
);
   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_IGNORE, ST_MODE_WR, ST_MODE_RD
   } state_t;

   logic [2:0] pin_in, sync1_reg, sync2_reg;
   logic       sck_prev_reg, armed_reg;
   logic       cs_s, sck_s, si_s, sck_rise, sck_fall;

   state_t               state_reg, state_next;
   logic [4:0]           bit_cnt_reg, bit_cnt_next;
   logic [7:0]           rx_reg, rx_next, rx_shift;
   logic [ADDR_BITS-1:0] addr_reg, addr_next, rd_addr, addr_adv;
   logic                 is_read_reg, is_read_next;
   logic                 load_reg, load_next;
   logic                 wrote_reg, wrote_next;
   logic                 so_reg, so_next;
   logic [7:0]           so_shift_reg, so_shift_next, load_byte;
   logic                 wr_strobe_reg, wr_strobe_next;
   logic [ADDR_BITS-1:0] wr_addr_reg, wr_addr_next;
   logic [7:0]           wr_data_reg, wr_data_next;
   logic                 cmd_err_reg, cmd_err_next;
   logic                 mem_we, rd_en;
   logic [7:0]           rd_data_reg;
   logic [7:0]           mem [2**ADDR_BITS];
   logic [1:0]           mode_sel;
   logic                 unused_holdn;

   assign pin_in       = {spi.CSn, spi.SCK, spi.SI};
   assign cs_s         = sync2_reg[2];
   assign sck_s        = sync2_reg[1];
   assign si_s         = sync2_reg[0];
   assign sck_rise     = sck_s & ~sck_prev_reg;
   assign sck_fall     = ~sck_s & sck_prev_reg;
   assign unused_holdn = spi.HOLDn;

   // Synchronizers reset low so a CSn held low through reset never looks like a fresh fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg    <= 3'b000;
         sync2_reg    <= 3'b000;
         sck_prev_reg <= 1'b0;
         armed_reg    <= 1'b0;
      end else begin
         sync1_reg    <= pin_in;
         sync2_reg    <= sync1_reg;
         sck_prev_reg <= sck_s;
         if (cs_s) armed_reg <= 1'b1;
      end
   end

`ifdef SRAM_RSP_MODE_REG_EN
   logic [7:0] mode_reg;
   logic       mode_we;

   always_ff @(posedge clk) begin
      if (rst)          mode_reg <= 8'h40;
      else if (mode_we) mode_reg <= rx_shift;
   end
   assign mode_sel = mode_reg[7:6];
`else
   assign mode_sel = 2'b01;
`endif

   // 00 holds the address, 10 wraps inside a 32-byte page, 01/11 run sequentially.
   always_comb begin
      case (mode_sel)
         2'b00:   addr_adv = addr_reg;
         2'b10:   addr_adv = {addr_reg[ADDR_BITS-1:5], addr_reg[4:0] + 5'd1};
         default: addr_adv = addr_reg + 1'b1;
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      rx_next        = rx_reg;
      rx_shift       = {rx_reg[6:0], si_s};
      addr_next      = addr_reg;
      is_read_next   = is_read_reg;
      load_next      = load_reg;
      wrote_next     = wrote_reg;
      so_next        = 1'b1;
      so_shift_next  = so_shift_reg;
      wr_strobe_next = 1'b0;
      wr_addr_next   = wr_addr_reg;
      wr_data_next   = wr_data_reg;
      cmd_err_next   = 1'b0;
      mem_we         = 1'b0;
      rd_en          = 1'b0;
      rd_addr        = addr_reg;
      load_byte      = rd_data_reg;
`ifdef SRAM_RSP_MODE_REG_EN
      mode_we        = 1'b0;
      if (state_reg == ST_MODE_RD) load_byte = mode_reg;
`endif
      if (!armed_reg || cs_s) begin
         state_next = ST_IDLE;
      end else begin
         if (state_reg == ST_RDATA || state_reg == ST_MODE_RD) begin
            so_next = so_reg;
            if (sck_fall) begin
               if (load_reg) begin
                  so_shift_next = load_byte;
                  so_next       = load_byte[7];
                  load_next     = 1'b0;
               end else begin
                  so_shift_next = {so_shift_reg[6:0], 1'b1};
                  so_next       = so_shift_reg[6];
               end
            end
         end
         if (sck_rise && state_reg != ST_IDLE && state_reg != ST_IGNORE) begin
            rx_next      = rx_shift;
            bit_cnt_next = bit_cnt_reg + 5'd1;
         end
         case (state_reg)
            ST_IDLE: begin
               // A rise seen together with the CSn fall is bit 0 of the command.
               state_next   = ST_CMD;
               load_next    = 1'b0;
               wrote_next   = 1'b0;
               bit_cnt_next = sck_rise ? 5'd1 : 5'd0;
               if (sck_rise) rx_next = rx_shift;
            end
            ST_CMD: if (sck_rise && bit_cnt_reg == 5'd7) begin
               bit_cnt_next = 5'd0;
               case (rx_shift)
                  8'h03: begin state_next = ST_ADDR; is_read_next = 1'b1; end
                  8'h02: begin state_next = ST_ADDR; is_read_next = 1'b0; end
`ifdef SRAM_RSP_MODE_REG_EN
                  8'h01: state_next = ST_MODE_WR;
                  8'h05: begin state_next = ST_MODE_RD; load_next = 1'b1; end
`endif
                  default: begin state_next = ST_IGNORE; cmd_err_next = 1'b1; end
               endcase
            end
            ST_ADDR: if (sck_rise) begin
               addr_next = {addr_reg[ADDR_BITS-2:0], si_s};
               if (bit_cnt_reg == 5'd23) begin
                  bit_cnt_next = 5'd0;
                  if (is_read_reg) begin
                     state_next = ST_RDATA;
                     rd_en      = 1'b1;
                     rd_addr    = addr_next;
                     load_next  = 1'b1;
                  end else begin
                     state_next = ST_WDATA;
                  end
               end
            end
            ST_WDATA: if (sck_rise && bit_cnt_reg == 5'd7) begin
               bit_cnt_next = 5'd0;
               addr_next    = addr_adv;
               if (!(mode_sel == 2'b00 && wrote_reg)) begin
                  mem_we         = 1'b1;
                  wr_strobe_next = 1'b1;
                  wr_addr_next   = addr_reg;
                  wr_data_next   = rx_shift;
                  wrote_next     = 1'b1;
               end
            end
            ST_RDATA: if (sck_rise && bit_cnt_reg == 5'd7) begin
               // Prefetch the next byte well ahead of the fall that shifts out its MSB.
               bit_cnt_next = 5'd0;
               addr_next    = addr_adv;
               rd_en        = 1'b1;
               rd_addr      = addr_adv;
               load_next    = 1'b1;
            end
`ifdef SRAM_RSP_MODE_REG_EN
            ST_MODE_WR: if (sck_rise && bit_cnt_reg == 5'd7) begin
               mode_we    = 1'b1;
               state_next = ST_IGNORE;
            end
            ST_MODE_RD: if (sck_rise && bit_cnt_reg == 5'd7) begin
               state_next = ST_IGNORE;
            end
`endif
            ST_IGNORE: state_next = ST_IGNORE;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= 5'd0;
         rx_reg        <= 8'h00;
         addr_reg      <= '0;
         is_read_reg   <= 1'b0;
         load_reg      <= 1'b0;
         wrote_reg     <= 1'b0;
         so_reg        <= 1'b1;
         so_shift_reg  <= 8'hFF;
         wr_strobe_reg <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= 8'h00;
         cmd_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         rx_reg        <= rx_next;
         addr_reg      <= addr_next;
         is_read_reg   <= is_read_next;
         load_reg      <= load_next;
         wrote_reg     <= wrote_next;
         so_reg        <= so_next;
         so_shift_reg  <= so_shift_next;
         wr_strobe_reg <= wr_strobe_next;
         wr_addr_reg   <= wr_addr_next;
         wr_data_reg   <= wr_data_next;
         cmd_err_reg   <= cmd_err_next;
      end
   end

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_reg] <= rx_shift;
      if (rd_en)  rd_data_reg <= mem[rd_addr];
   end

   assign spi.SO    = so_reg;
   assign selected  = armed_reg & ~cs_s;
   assign wr_strobe = wr_strobe_reg;
   assign wr_addr   = wr_addr_reg;
   assign wr_data   = wr_data_reg;
   assign cmd_err   = cmd_err_reg;
endmodule

// File: tb/tb_sram_23lc1024_responder.sv
// Self-checking bench for sram_23lc1024_responder: directed scenarios plus randomized
// write/read-back traffic scored against a plain byte-array model of the SRAM.
module tb_sram_23lc1024_responder;
   localparam int AB    = 10;
   localparam int DEPTH = 1 << AB;
   localparam int HALF  = 6;

   typedef logic [7:0] bq_t [$];
   typedef struct packed {
      logic [AB-1:0] a;
      logic [7:0]    d;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          selected, wr_strobe, cmd_err;
   logic [AB-1:0] wr_addr;
   logic [7:0]    wr_data;

   int   vectors = 0;
   int   miscompares = 0;
   int   strobe_cnt = 0;
   int   err_cnt = 0;
   exp_t exp_q [$];
   logic [7:0] ref_mem [DEPTH];

   always #5 clk = ~clk;

   sram_23lc1024_responder_if spi ();

   sram_23lc1024_responder #(.ADDR_BITS(AB)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi       (spi),
      .selected  (selected),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cmd_err   (cmd_err)
   );

   // Strobe scoreboard: each committed byte must match the next model expectation.
   always @(negedge clk) begin
      exp_t e;
      if (cmd_err === 1'b1) err_cnt++;
      if (wr_strobe === 1'b1) begin
         strobe_cnt++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL strobe_unexpected: got addr=%h data=%h, required no strobe", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== {e.a, e.d}) begin
               miscompares++;
               $display("FAIL strobe: got addr=%h data=%h, required addr=%h data=%h", wr_addr, wr_data, e.a, e.d);
            end
         end
      end
   end

   function automatic void model_write(input int a, input logic [7:0] d);
      exp_t e;
      e.a = AB'(a % DEPTH);
      e.d = d;
      ref_mem[a % DEPTH] = d;
      exp_q.push_back(e);
   endfunction

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'hFF;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi.SI = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = spi.SO;
         spi.SCK = 1'b1;
         repeat (HALF) @(negedge clk);
         spi.SCK = 1'b0;
      end
   endtask

   task automatic cs_start();
      spi.CSn = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (2) @(negedge clk);
      spi.CSn = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
      logic [7:0] rx;
      xfer(cmd, 8, rx);
      xfer(addr[23:16], 8, rx);
      xfer(addr[15:8], 8, rx);
      xfer(addr[7:0], 8, rx);
   endtask

   task automatic spi_write(input logic [23:0] addr, input bq_t data);
      logic [7:0] rx;
      $display("write addr=%h bytes=%0d", addr, data.size());
      cs_start();
      send_hdr(8'h02, addr);
      foreach (data[i]) xfer(data[i], 8, rx);
      cs_end();
   endtask

   task automatic spi_read(input logic [23:0] addr, input int n, output bq_t got);
      logic [7:0] rx;
      got = {};
      cs_start();
      send_hdr(8'h03, addr);
      for (int i = 0; i < n; i++) begin
         xfer(8'($urandom), 8, rx);
         got.push_back(rx);
      end
      cs_end();
      $display("read  addr=%h bytes=%0d", addr, n);
   endtask

   task automatic test_reset();
      if ({spi.SO, selected, wr_strobe, wr_addr, wr_data, cmd_err} !== {1'b1, 1'b0, 1'b0, {AB{1'b0}}, 8'h00, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got so=%b sel=%b stb=%b addr=%h data=%h err=%b, required 1 0 0 000 00 0",
                  spi.SO, selected, wr_strobe, wr_addr, wr_data, cmd_err);
      end
      vectors++;
   endtask

   task automatic test_write_read();
      bq_t d, got;
      d = {};
      d.push_back(8'hA5);
      model_write(32'h10, 8'hA5);
      spi_write(24'h000010, d);
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL wr_missing: got %0d pending, required 0", exp_q.size()); end
      spi_read(24'h000010, 1, got);
      vectors++;
      if (got[0] !== 8'hA5) begin miscompares++; $display("FAIL rd_single: got %h, required a5", got[0]); end
   endtask

   task automatic test_wrap();
      bq_t d, got;
      d = {};
      d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
      foreach (d[i]) model_write(32'h3FF + i, d[i]);
      spi_write(24'h0003FF, d);
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_missing: got %0d pending, required 0", exp_q.size()); end
      spi_read(24'h0003FF, 3, got);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (got[i] !== ref_mem[(32'h3FF + i) % DEPTH]) begin
            miscompares++;
            $display("FAIL wrap_read[%0d]: got %h, required %h", i, got[i], ref_mem[(32'h3FF + i) % DEPTH]);
         end
      end
   endtask

   task automatic test_partial();
      bq_t d, got;
      logic [7:0] v, rx;
      int s0;
      v = 8'($urandom);
      d = {};
      d.push_back(v);
      model_write(32'h21, v);
      spi_write(24'h000021, d);
      s0 = strobe_cnt;
      model_write(32'h20, 8'h5A);
      cs_start();
      send_hdr(8'h02, 24'h000020);
      xfer(8'h5A, 8, rx);
      xfer(8'($urandom), 5, rx);
      cs_end();
      vectors++;
      if (strobe_cnt - s0 != 1 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL partial_strobes: got %0d strobes, required 1", strobe_cnt - s0);
      end
      spi_read(24'h000020, 2, got);
      vectors++;
      if ({got[0], got[1]} !== {8'h5A, v}) begin
         miscompares++;
         $display("FAIL partial_read: got %h %h, required 5a %h", got[0], got[1], v);
      end
   endtask

   task automatic test_bad_cmd();
      logic [7:0] rx;
      bq_t d, got;
      int e0, a;
      e0 = err_cnt;
      cs_start();
      vectors++;
      if (selected !== 1'b1) begin miscompares++; $display("FAIL selected: got %b, required 1", selected); end
      xfer(8'h9F, 8, rx);
      repeat (4) @(negedge clk);
      vectors++;
      if (err_cnt != e0 + 1) begin miscompares++; $display("FAIL cmd_err_count: got %0d, required 1", err_cnt - e0); end
      for (int i = 0; i < 2; i++) begin
         xfer(8'($urandom), 8, rx);
         vectors++;
         if (rx !== 8'hFF) begin miscompares++; $display("FAIL ignore_so[%0d]: got %h, required ff", i, rx); end
      end
      cs_end();
      a = 32'h100 + int'($urandom_range(0, 255));
      d = {};
      d.push_back(8'($urandom));
      model_write(a, d[0]);
      spi_write(24'(a), d);
      spi_read(24'(a), 1, got);
      vectors++;
      if (got[0] !== ref_mem[a]) begin miscompares++; $display("FAIL after_bad_cmd: got %h, required %h", got[0], ref_mem[a]); end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] rx;
      bq_t d;
      int s0;
      cs_start();
      send_hdr(8'h03, 24'h000010);
      xfer(8'hFF, 3, rx);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({spi.SO, selected} !== 2'b10) begin
         miscompares++;
         $display("FAIL rst_mid_read: got so=%b sel=%b, required so=1 sel=0", spi.SO, selected);
      end
      s0 = strobe_cnt;
      rst = 1'b0;
      send_hdr(8'h02, 24'h000050);
      xfer(8'h77, 8, rx);
      vectors++;
      if (strobe_cnt != s0 || spi.SO !== 1'b1 || selected !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_held_cs: got strobes=%0d so=%b sel=%b, required 0 1 0", strobe_cnt - s0, spi.SO, selected);
      end
      cs_end();
      d = {};
      d.push_back(8'hC3);
      model_write(32'h40, 8'hC3);
      spi_write(24'h000040, d);
      vectors++;
      if (strobe_cnt != s0 + 1 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL write_after_rst: got %0d strobes, required 1", strobe_cnt - s0);
      end
   endtask

   task automatic test_random();
      bq_t d, got;
      int a, n;
      logic [23:0] hdr;
      for (int t = 0; t < 10; t++) begin
         a = int'($urandom_range(0, DEPTH - 1));
         n = int'($urandom_range(1, 4));
         d = {};
         for (int i = 0; i < n; i++) begin
            d.push_back(8'($urandom));
            model_write(a + i, d[i]);
         end
         hdr = {14'($urandom), AB'(a)};
         spi_write(hdr, d);
         vectors++;
         if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_missing[%0d]: got %0d pending, required 0", t, exp_q.size()); end
         hdr = {14'($urandom), AB'(a)};
         spi_read(hdr, n, got);
         for (int i = 0; i < n; i++) begin
            vectors++;
            if (got[i] !== ref_mem[(a + i) % DEPTH]) begin
               miscompares++;
               $display("FAIL rand_read[%0d.%0d]: got %h, required %h", t, i, got[i], ref_mem[(a + i) % DEPTH]);
            end
         end
      end
   endtask

`ifdef SRAM_RSP_MODE_REG_EN
   task automatic test_mode_reg();
      logic [7:0] rx;
      bq_t d, got;
      int pa;
      cs_start(); xfer(8'h01, 8, rx); xfer(8'h80, 8, rx); xfer(8'h00, 8, rx); cs_end();
      cs_start(); xfer(8'h05, 8, rx); xfer(8'h00, 8, rx); cs_end();
      vectors++;
      if (rx !== 8'h80) begin miscompares++; $display("FAIL rdmr: got %h, required 80", rx); end
      d = {};
      d.push_back(8'h01); d.push_back(8'h02); d.push_back(8'h03);
      for (int i = 0; i < 3; i++) begin
         pa = (32'h1F - 32'h1F % 32) + (32'h1F + i) % 32;
         model_write(pa, d[i]);
      end
      spi_write(24'h00001F, d);
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL page_missing: got %0d pending, required 0", exp_q.size()); end
      spi_read(24'h00001F, 3, got);
      vectors++;
      if ({got[0], got[1], got[2]} !== {ref_mem[31], ref_mem[0], ref_mem[1]}) begin
         miscompares++;
         $display("FAIL page_read: got %h %h %h, required %h %h %h", got[0], got[1], got[2], ref_mem[31], ref_mem[0], ref_mem[1]);
      end
      cs_start(); xfer(8'h01, 8, rx); xfer(8'h40, 8, rx); cs_end();
   endtask
`endif

   initial begin
      spi.CSn   = 1'b1;
      spi.SCK   = 1'b0;
      spi.SI    = 1'b0;
      spi.HOLDn = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (HALF) @(negedge clk);
      test_reset();
      test_write_read();
      test_wrap();
      test_partial();
      test_bad_cmd();
      test_reset_mid_read();
`ifdef SRAM_RSP_MODE_REG_EN
      test_mode_reg();
`endif
      test_random();
      repeat (10) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL final_pending: got %0d, required 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sram_23lc1024_responder.md
# sram_23lc1024_responder

SPI responder that emulates a 23LC1024 serial SRAM on its CSn/SCK/SI/SO/HOLDn pins, backed by an internal byte array. It is the device-side counterpart of our 23LC1024 byte-access controller. It lets that controller, and any SPI-mode-0 initiator, be exercised on-chip or in simulation without the physical IC. All pin inputs are oversampled in the system clock domain.

## Interface
- ADDR_BITS, 10, implemented address width; array is 2^ADDR_BITS bytes; upper received address bits ignored
- clk  in  1  system clock; must be at least 8x SCK frequency
- rst  in  1  synchronous, active-high reset
- CSn  in  1  chip select, active low (asynchronous to clk)
- SCK  in  1  serial clock, mode 0 (asynchronous to clk)
- SI  in  1  serial data from initiator
- HOLDn  in  1  ignored (hold feature not implemented)
- SO  out  1  serial data to initiator; 1 when not driving read data
- selected  out  1  synchronized ~CSn
- wr_strobe  out  1  one-clk pulse per byte committed to the array
- wr_addr  out  ADDR_BITS  address of the committed byte, valid with wr_strobe
- wr_data  out  8  committed byte, valid with wr_strobe
- cmd_err  out  1  one-clk pulse on an unsupported command byte

## Operation
- CSn, SCK and SI each pass through a 2-FF synchronizer. SCK rise and fall are detected from the last two synchronized samples.
- Bits are sampled MSB first on SCK rise. SO changes on SCK fall.
- States:
  - IDLE: CSn high. On CSn fall → CMD, with bit counter 0.
  - CMD: after 8 bits, 0x03 → ADDR (read) and 0x02 → ADDR (write). Anything else pulses cmd_err → IGNORE.
  - ADDR: collects 24 bits; address register = low ADDR_BITS. Then → RDATA or WDATA.
  - WDATA: after each 8th bit, write to mem[addr], pulse wr_strobe/wr_addr/wr_data, then advance addr.
  - RDATA: on the 32nd address rise, issue a synchronous read of mem[addr]. On the following SCK fall, load the shift register and drive bit 7. After each 8th rise, advance addr and prefetch the next byte. The next fall drives its MSB.
  - IGNORE: SO=1, wait for CSn high.
- Any synchronized CSn rise in any state → IDLE, SO=1. A partial byte is discarded with no write.
- Address advance: sequential mode wraps 2^ADDR_BITS−1 → 0.
- Reset:
  - outputs SO=1, selected=0, wr_strobe=0, wr_addr=0, wr_data=0, cmd_err=0; state IDLE.
  - If CSn is low when rst deasserts, the block stays in IDLE until CSn has been seen high.
  - Array contents are not cleared and are undefined until written.

## Timing
- CSn/SCK/SI to internal: 2 clk synchronizer plus 1 clk edge detect.
- wr_strobe fires 3 clk after the synchronized rise of the 8th data bit's SCK.
- Read data: array read completes 1 clk after the prefetch request, at least 2 clk before the next detected SCK fall given the 8x clk ratio.
- SO is valid by 4 clk after SCK fall. The initiator's half-period must therefore be at least 4 clk.
- SCK edges while CSn is high are ignored.
- CSn fall and SCK rise in the same synchronized sample: the CSn fall is processed first and the SCK rise counts as bit 0.

## Configuration
- SRAM_RSP_MODE_REG_EN defined:
  - Adds an 8-bit mode register, reset value 0x40 (sequential).
  - Command 0x01 (WRMR) writes it from the next byte. Command 0x05 (RDMR) returns it on SO. Further bytes in either transaction are ignored.
  - Mode bits [7:6]:
    - 00 byte mode: addr never advances; writes after the first byte are dropped; reads repeat the same byte.
    - 10 page mode: addr[4:0] wraps within a 32-byte page.
    - 01 sequential mode.
    - 11 is treated as sequential.
- Without the macro: 0x01 and 0x05 are unsupported (cmd_err, IGNORE), and the block is always sequential.

## Test plan
- WRITE 0x02, addr 0x000010, data 0xA5, CSn high; then READ 0x03 at 0x000010 → one wr_strobe with wr_addr=0x010 and wr_data=0xA5; SO shifts 0xA5.
- WRITE at 0x0003FF with data 0x11,0x22,0x33 (ADDR_BITS=10) → strobes at 0x3FF, 0x000, 0x001. A 3-byte READ from 0x3FF returns 0x11,0x22,0x33.
- WRITE at 0x20 of 0x5A, then CSn high after 5 bits of a second byte → exactly one wr_strobe; reading 0x21 returns its prior value.
- Command 0x9F → one cmd_err pulse; SO stays 1 through 16 further clocks. A following READ transaction works normally.
- Assert rst mid-READ with CSn held low → SO=1 and no strobes. After CSn goes high then low, a new WRITE is accepted.
- With SRAM_RSP_MODE_REG_EN: WRMR 0x80, then WRITE at 0x1F of 0x01,0x02,0x03 → strobes at 0x01F, 0x000, 0x001. RDMR returns 0x80.
